mont_r2_precompute: RTL and testbench

- Computes the Montgomery conversion constants for an odd modulus P: R mod P and R^2 mod P, with R = 2^WIDTH.
- Sits directly upstream of the bit-serial Montgomery multiplier.
- R2 is fed to that multiplier as operand b, together with a plain operand a, so that MontMul(a, R2) = a*R mod P and a enters the Montgomery domain.
- Uses sequential doubling with conditional subtraction: one doubling per clock, no multiplier hardware.

---
 rtl/mont_r2_precompute.sv | 132 +++++++++++++
 tb/tb_mont_r2_precompute.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_r2_precompute.sv
// Computes R mod P and R^2 mod P (R = 2^WIDTH) for an odd modulus by repeated
// modular doubling, one doubling per clock; feeds the Montgomery multiplier.
module mont_r2_precompute #(
  parameter int unsigned WIDTH = 255,
  parameter int unsigned CNT_W = $clog2(2*WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] P,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] r_mod_p,
  output logic [WIDTH-1:0] r2_mod_p
);

  localparam logic [CNT_W-1:0] CNT_R  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_R2 = CNT_W'(2*WIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_p, w_p_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic [WIDTH-1:0] r_r, w_r_nxt;
  logic [WIDTH-1:0] r_r2, w_r2_nxt;

  logic [WIDTH:0]   w_t;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_step;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_p_bad;

  // One modular doubling; acc < p keeps the result below p after one subtract.
  assign w_t       = {r_acc, 1'b0};
  assign w_ge      = (w_t >= {1'b0, r_p});
  assign w_diff    = WIDTH'(w_t - {1'b0, r_p});
  assign w_step    = w_ge ? w_diff : w_t[WIDTH-1:0];
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_p_bad   = ~P[0] || (P < WIDTH'(3));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_p     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_r     <= '0;
      r_r2    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_p     <= w_p_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_r     <= w_r_nxt;
      r_r2    <= w_r2_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_p_nxt     = r_p;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_r_nxt     = r_r;
    w_r2_nxt    = r_r2;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_p_nxt    = P;
          w_done_nxt = 1'b0;
          w_err_nxt  = 1'b0;
          w_r_nxt    = '0;
          w_r2_nxt   = '0;
          w_busy_nxt = 1'b1;
          // Invalid modulus short-circuits through FIN; busy masks start there.
          if (w_p_bad) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_acc_nxt   = WIDTH'(1);
            w_cnt_nxt   = '0;
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        w_acc_nxt = w_step;
        w_cnt_nxt = w_cnt_inc;
        if (w_cnt_inc == CNT_R) begin
          w_r_nxt = w_step;
        end
        if (w_cnt_inc == CNT_R2) begin
          w_r2_nxt    = w_step;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FIN: begin
        w_err_nxt   = 1'b1;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign r_mod_p  = r_r;
  assign r2_mod_p = r_r2;

endmodule

// File: tb/tb_mont_r2_precompute.sv
// Scoreboard bench for mont_r2_precompute: an 8-bit instance for directed cases
// and a full-width instance for the 2^255-19 modulus.
module tb_mont_r2_precompute;

  localparam int unsigned W  = 8;
  localparam int unsigned WB = 255;

  typedef struct {
    logic [WB-1:0] r;
    logic [WB-1:0] r2;
    logic          err;
    int unsigned   edge_n;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [W-1:0]  p;
  logic          busy, done, err;
  logic [W-1:0]  r, r2;
  logic          start_b;
  logic [WB-1:0] p_b;
  logic          busy_b, done_b, err_b;
  logic [WB-1:0] r_b, r2_b;

  exp_t          q8[$];
  exp_t          qb[$];
  int unsigned   cyc = 0;
  int            total = 0;
  int            bad = 0;
  logic          prev8 = 1'b0;
  logic          prevb = 1'b0;
  exp_t          e8, eb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mont_r2_precompute #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset_n), .start(start), .P(p), .busy(busy), .done(done),
    .err(err), .r_mod_p(r), .r2_mod_p(r2)
  );

  mont_r2_precompute dut_b (
    .clk(clk), .reset(reset_n), .start(start_b), .P(p_b), .busy(busy_b), .done(done_b),
    .err(err_b), .r_mod_p(r_b), .r2_mod_p(r2_b)
  );

  task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor for the 8-bit instance: every rising done is matched to a queued result.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev8 = 1'b0;
    end else begin
      if (done && !prev8) begin
        if (q8.size() == 0) begin
          total++; bad++;
          $display("FAIL mon8_unexpected: done rose with r=%0d and nothing queued", r);
        end else begin
          e8 = q8.pop_front();
          chk("mon8_r_mod_p", WB'(r), e8.r);
          chk("mon8_r2_mod_p", WB'(r2), e8.r2);
          chk("mon8_err", WB'(err), WB'(e8.err));
          chk("mon8_busy", WB'(busy), WB'(0));
          chk("mon8_done_edge", WB'(cyc), WB'(e8.edge_n));
        end
      end
      prev8 = done;
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      prevb = 1'b0;
    end else begin
      if (done_b && !prevb) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL monb_unexpected: done rose with nothing queued");
        end else begin
          eb = qb.pop_front();
          chk("monb_r_mod_p", r_b, eb.r);
          chk("monb_r2_mod_p", r2_b, eb.r2);
          chk("monb_err", WB'(err_b), WB'(eb.err));
          chk("monb_done_edge", WB'(cyc), WB'(eb.edge_n));
        end
      end
      prevb = done_b;
    end
  end

  // Called at a negedge; the start is sampled on the next posedge (edge k).
  task automatic issue8(input logic [W-1:0] pv, input logic [W-1:0] er, input logic [W-1:0] er2,
                        input logic eerr, input bit track);
    exp_t e;
    start = 1'b1;
    p     = pv;
    if (track) begin
      e.r      = WB'(er);
      e.r2     = WB'(er2);
      e.err    = eerr;
      e.edge_n = cyc + 1 + (eerr ? 1 : 2*W);
      q8.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done8(input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL wait_done8: done=%0d after %0d cycles, required 1", done, maxc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t eb0;
    bit   seen_b;
    reset_n = 1'b0;
    start   = 1'b0;
    p       = '0;
    start_b = 1'b0;
    p_b     = '0;
    #12;
    chk("rst_busy", WB'(busy), WB'(0));
    chk("rst_done", WB'(done), WB'(0));
    chk("rst_err", WB'(err), WB'(0));
    chk("rst_r", WB'(r), WB'(0));
    chk("rst_r2", WB'(r2), WB'(0));
    chk("rst_busy_b", WB'(busy_b), WB'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // P=13: intermediate capture of R mod P at edge k+8, P changes mid-run ignored
    issue8(8'd13, 8'd9, 8'd3, 1'b0, 1'b1);
    p = 8'd0;
    repeat (7) @(negedge clk);
    chk("t1_r_before_k8", WB'(r), WB'(0));
    chk("t1_busy_k7", WB'(busy), WB'(1));
    @(negedge clk);
    chk("t1_r_at_k8", WB'(r), WB'(9));
    wait_done8(20);
    repeat (3) @(negedge clk);
    chk("t1_hold_r", WB'(r), WB'(9));
    chk("t1_hold_r2", WB'(r2), WB'(3));
    chk("t1_hold_done", WB'(done), WB'(1));

    // Near-2^W moduli, including the t >= p boundary at P=255
    issue8(8'd251, 8'd5, 8'd25, 1'b0, 1'b1);
    wait_done8(20);
    issue8(8'd255, 8'd1, 8'd1, 1'b0, 1'b1);
    wait_done8(20);

    // Invalid moduli and the smallest valid one
    issue8(8'd12, 8'd0, 8'd0, 1'b1, 1'b1);
    wait_done8(5);
    issue8(8'd1, 8'd0, 8'd0, 1'b1, 1'b1);
    wait_done8(5);
    issue8(8'd3, 8'd1, 8'd1, 1'b0, 1'b1);
    wait_done8(20);

    // Start while busy is ignored
    issue8(8'd13, 8'd9, 8'd3, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    issue8(8'd251, 8'd5, 8'd25, 1'b0, 1'b0);
    wait_done8(20);

    // Asynchronous reset with results held, then mid-run
    #2 reset_n = 1'b0;
    #1;
    chk("arst_idle_done", WB'(done), WB'(0));
    chk("arst_idle_r", WB'(r), WB'(0));
    chk("arst_idle_r2", WB'(r2), WB'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue8(8'd251, 8'd5, 8'd25, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("arst_run_busy_before", WB'(busy), WB'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_run_busy", WB'(busy), WB'(0));
    chk("arst_run_done", WB'(done), WB'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue8(8'd13, 8'd9, 8'd3, 1'b0, 1'b1);
    wait_done8(20);

    // Back-to-back: new start on the cycle after done rises
    issue8(8'd251, 8'd5, 8'd25, 1'b0, 1'b1);
    chk("b2b_done_cleared", WB'(done), WB'(0));
    chk("b2b_r_cleared", WB'(r), WB'(0));
    wait_done8(20);

    // Full-width instance, P = 2^255 - 19
    start_b    = 1'b1;
    p_b        = {WB{1'b1}} - WB'(18);
    eb0.r      = WB'(19);
    eb0.r2     = WB'(361);
    eb0.err    = 1'b0;
    eb0.edge_n = cyc + 1 + 2*WB;
    qb.push_back(eb0);
    @(negedge clk);
    start_b = 1'b0;
    seen_b  = 1'b0;
    for (int i = 0; i < 600 && !seen_b; i++) begin
      @(negedge clk);
      if (done_b) seen_b = 1'b1;
    end
    if (!seen_b) begin
      total++; bad++;
      $display("FAIL wait_done_b: done_b=%0d after 600 cycles, required 1", done_b);
    end

    repeat (3) @(negedge clk);
    chk("drain_q8", WB'(q8.size()), WB'(0));
    chk("drain_qb", WB'(qb.size()), WB'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
